// File: rtl/ifid_queue.sv
// IF->ID boundary buffer: DEPTH-entry circular FIFO of {pc, instr} with
// flush and pre-sliced decode fields. Optional zero-latency path: IFID_BYPASS_EN.
module ifid_queue #(
  parameter int unsigned       DEPTH  = 2,
  parameter int unsigned       XLEN   = 32,
  parameter logic [XLEN-1:0]   BUBBLE = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [XLEN-1:0]       in_instr,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_pc,
  output logic [XLEN-1:0]       out_instr,
  output logic [4:0]            read_reg1,
  output logic [4:0]            read_reg2,
  output logic [4:0]            write_addr,
  output logic [6:0]            opcode,
  output logic [2:0]            funct3,
  output logic [6:0]            funct7,
  output logic                  is_float,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [CW-1:0]   rd_ptr;
  logic [CW-1:0]   wr_ptr;
  logic [XLEN-1:0] last_pc;
  logic [AW-1:0]   rd_idx;
  logic [AW-1:0]   wr_idx;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;

  assign rd_idx = rd_ptr[AW-1:0];
  assign wr_idx = wr_ptr[AW-1:0];
  assign empty  = (rd_ptr == wr_ptr);
  assign full   = (rd_idx == wr_idx) && (rd_ptr[AW] != wr_ptr[AW]);
  assign count  = wr_ptr - rd_ptr;
  assign in_ready = !full;

`ifdef IFID_BYPASS_EN
  logic bypass;
  logic bypass_take;

  // An empty queue forwards the fetch entry straight to decode.
  assign bypass      = empty && in_valid && !flush;
  assign bypass_take = bypass && out_ready;
  assign out_valid   = !empty || bypass;
  assign pop         = !empty && out_ready && !flush;
  assign push        = in_valid && !full && !flush && !bypass_take;
`else
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready && !flush;
  assign push      = in_valid && in_ready && !flush;
`endif

  // Head entry mux; empty queue shows the last popped PC and a bubble.
  always_comb begin
    out_pc    = last_pc;
    out_instr = BUBBLE;
    if (!empty) begin
      out_pc    = pc_mem[rd_idx];
      out_instr = instr_mem[rd_idx];
    end
`ifdef IFID_BYPASS_EN
    else if (bypass) begin
      out_pc    = in_pc;
      out_instr = in_instr;
    end
`endif
  end

  assign opcode     = out_instr[6:0];
  assign write_addr = out_instr[11:7];
  assign funct3     = out_instr[14:12];
  assign read_reg1  = out_instr[19:15];
  assign read_reg2  = out_instr[24:20];
  assign funct7     = out_instr[31:25];
  assign is_float   = (opcode == 7'b0000111) || (opcode == 7'b0100111) ||
                      (opcode == 7'b1010011);

  // Storage array is not reset; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_idx]    <= in_pc;
      instr_mem[wr_idx] <= in_instr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      last_pc <= '0;
    end else if (flush) begin
      rd_ptr  <= wr_ptr;
      last_pc <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + CW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + CW'(1);
        last_pc <= pc_mem[rd_idx];
      end
`ifdef IFID_BYPASS_EN
      if (bypass_take) last_pc <= in_pc;
`endif
    end
  end

endmodule
